// File: rtl/eeprom_arb_pkg.sv
// Shared constants and types for the two-port EEPROM command arbiter.
package eeprom_arb_pkg;

  localparam int unsigned ADDR_W          = 11;
  localparam int unsigned DATA_W          = 8;
  localparam int unsigned CNT_W           = 16;
  localparam int unsigned TIMEOUT_CYC_DEF = 20000;

  localparam logic [3:0] ST_IDLE     = 4'b0001;
  localparam logic [3:0] ST_WAIT_ACK = 4'b0010;
  localparam logic [3:0] ST_RESP     = 4'b0100;
  localparam logic [3:0] ST_GAP      = 4'b1000;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  // Request fields captured at grant time
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

endpackage

// File: rtl/eeprom_arb_rr_arb2.sv
// Two-way round-robin grant; a tie goes to the port not granted last.
module rr_arb2
  import eeprom_arb_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req_a_i,
  input  logic req_b_i,
  input  logic accept_i,
  output logic grant_c
);

  logic last_q, last_d;

  assign grant_c = (req_a_i && (!req_b_i || (last_q == PORT_B))) ? PORT_A : PORT_B;

  always_comb begin
    last_d = last_q;
    if (accept_i) last_d = grant_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= PORT_B;
    else        last_q <= last_d;
  end

endmodule

// File: rtl/eeprom_arb.sv
// Arbitrates two requesters onto one EEPROM serial engine, with ack timeout.
module eeprom_arb
  import eeprom_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              A_REQ,
  input  logic              B_REQ,
  input  logic              A_WE,
  input  logic              B_WE,
  input  logic [ADDR_W-1:0] A_ADDR,
  input  logic [ADDR_W-1:0] B_ADDR,
  input  logic [DATA_W-1:0] A_WDATA,
  input  logic [DATA_W-1:0] B_WDATA,
  output logic              A_DONE,
  output logic              B_DONE,
  output logic              ERR,
  output logic [DATA_W-1:0] RDATA,
  output logic              BUSY,
  output logic              E_WR,
  output logic              E_RD,
  output logic [ADDR_W-1:0] E_ADDR,
  inout  wire  [DATA_W-1:0] E_DATA,
  input  logic              E_ACK
);

  logic [3:0]        state_q, state_d;
  req_t              req_q, req_d, sel_req_c;
  logic              port_q, port_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              e_wr_q, e_wr_d, e_rd_q, e_rd_d;
  logic [ADDR_W-1:0] e_addr_q, e_addr_d;
  logic              a_done_q, a_done_d, b_done_q, b_done_d;
  logic              err_q, err_d, busy_q, busy_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              grant_c, accept_c, tmo_c, drive_c;

  rr_arb2 u_arb (
    .clk      (CLK),
    .rst_n    (RESET),
    .req_a_i  (A_REQ),
    .req_b_i  (B_REQ),
    .accept_i (accept_c),
    .grant_c  (grant_c)
  );

  assign sel_req_c = (grant_c == PORT_A) ? {A_WE, A_ADDR, A_WDATA} : {B_WE, B_ADDR, B_WDATA};
  assign tmo_c     = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  // Bus is only ours while a write command is outstanding
  assign drive_c = (state_q == ST_WAIT_ACK) && req_q.we;
  assign E_DATA  = drive_c ? req_q.wdata : {DATA_W{1'bz}};

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    port_d   = port_q;
    cnt_d    = cnt_q;
    e_wr_d   = e_wr_q;
    e_rd_d   = e_rd_q;
    e_addr_d = e_addr_q;
    a_done_d = 1'b0;
    b_done_d = 1'b0;
    err_d    = err_q;
    rdata_d  = rdata_q;
    accept_c = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (A_REQ || B_REQ) begin
          accept_c = 1'b1;
          port_d   = grant_c;
          req_d    = sel_req_c;
          e_wr_d   = sel_req_c.we;
          e_rd_d   = !sel_req_c.we;
          e_addr_d = sel_req_c.addr;
          cnt_d    = '0;
          state_d  = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        // A coincident ack beats the timeout
        if (E_ACK || tmo_c) begin
          e_wr_d   = 1'b0;
          e_rd_d   = 1'b0;
          cnt_d    = '0;
          err_d    = !E_ACK;
          a_done_d = (port_q == PORT_A);
          b_done_d = (port_q == PORT_B);
          if (E_ACK && !req_q.we) rdata_d = E_DATA;
          state_d  = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: begin
        err_d   = 1'b0;
        state_d = ST_GAP;
      end
      ST_GAP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        e_wr_d  = 1'b0;
        e_rd_d  = 1'b0;
        err_d   = 1'b0;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= ST_IDLE;
      req_q    <= '0;
      port_q   <= PORT_A;
      cnt_q    <= '0;
      e_wr_q   <= 1'b0;
      e_rd_q   <= 1'b0;
      e_addr_q <= '0;
      a_done_q <= 1'b0;
      b_done_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      port_q   <= port_d;
      cnt_q    <= cnt_d;
      e_wr_q   <= e_wr_d;
      e_rd_q   <= e_rd_d;
      e_addr_q <= e_addr_d;
      a_done_q <= a_done_d;
      b_done_q <= b_done_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      busy_q   <= busy_d;
    end
  end

  assign A_DONE = a_done_q;
  assign B_DONE = b_done_q;
  assign ERR    = err_q;
  assign RDATA  = rdata_q;
  assign BUSY   = busy_q;
  assign E_WR   = e_wr_q;
  assign E_RD   = e_rd_q;
  assign E_ADDR = e_addr_q;

endmodule

// File: tb/tb_eeprom_arb.sv
// Randomized self-checking bench for eeprom_arb against a transaction-level model.
module tb_eeprom_arb;

  localparam int TO = 100;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        A_REQ, B_REQ, A_WE, B_WE, E_ACK;
  logic [10:0] A_ADDR, B_ADDR;
  logic [7:0]  A_WDATA, B_WDATA;
  logic        A_DONE, B_DONE, ERR, BUSY, E_WR, E_RD;
  logic [7:0]  RDATA;
  logic [10:0] E_ADDR;
  wire  [7:0]  E_DATA;
  logic [7:0]  eng_val;

  int   checks = 0;
  int   failures = 0;
  bit   last_is_b;
  logic [7:0] exp_rdata;

  always #5 CLK = ~CLK;

  // Engine model: owns the data bus whenever no write command is active
  assign E_DATA = E_WR ? 8'hzz : eng_val;

  eeprom_arb #(.TIMEOUT_CYC(TO)) dut (
    .CLK(CLK), .RESET(RESET),
    .A_REQ(A_REQ), .B_REQ(B_REQ), .A_WE(A_WE), .B_WE(B_WE),
    .A_ADDR(A_ADDR), .B_ADDR(B_ADDR), .A_WDATA(A_WDATA), .B_WDATA(B_WDATA),
    .A_DONE(A_DONE), .B_DONE(B_DONE), .ERR(ERR), .RDATA(RDATA), .BUSY(BUSY),
    .E_WR(E_WR), .E_RD(E_RD), .E_ADDR(E_ADDR), .E_DATA(E_DATA), .E_ACK(E_ACK)
  );

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic apply_reset;
    @(negedge CLK);
    RESET = 1'b0;
    {A_REQ, B_REQ, A_WE, B_WE, E_ACK} = '0;
    A_ADDR = '0; B_ADDR = '0; A_WDATA = '0; B_WDATA = '0;
    eng_val = 8'h00;
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    last_is_b = 1'b1;
    exp_rdata = 8'h00;
  endtask

  // One complete transaction; lat = WAIT_ACK cycle index in which E_ACK is given
  task automatic do_txn(input bit ra, input bit rb, input bit wa, input bit wb,
                        input logic [10:0] aa, input logic [10:0] ab,
                        input logic [7:0] da, input logic [7:0] db,
                        input int lat, input logic [7:0] rd, input bit keep,
                        input string tag);
    bit g_b, we, acked;
    logic [10:0] ad;
    logic [7:0] wd;
    int e;
    @(negedge CLK);
    A_REQ = ra; B_REQ = rb; A_WE = wa; B_WE = wb;
    A_ADDR = aa; B_ADDR = ab; A_WDATA = da; B_WDATA = db;
    g_b = !(ra && (!rb || last_is_b));
    last_is_b = g_b;
    we = g_b ? wb : wa;
    ad = g_b ? ab : aa;
    wd = g_b ? db : da;
    acked = (lat < TO);
    e = acked ? lat : TO - 1;
    tick;
    checks++;
    if (E_WR !== we || E_RD !== !we || E_ADDR !== ad || BUSY !== 1'b1) begin
      failures++;
      $display("FAIL %s start: E_WR=%b E_RD=%b E_ADDR=%h BUSY=%b want %b %b %h 1",
               tag, E_WR, E_RD, E_ADDR, BUSY, we, !we, ad);
    end
    checks++;
    if (E_DATA !== (we ? wd : eng_val)) begin
      failures++;
      $display("FAIL %s start_data: E_DATA=%h want %h", tag, E_DATA, we ? wd : eng_val);
    end
    for (int i = 0; i <= e; i++) begin
      @(negedge CLK);
      if (i == 0) begin
        if (!keep) begin A_REQ = 1'b0; B_REQ = 1'b0; end
        A_WE = 1'($urandom); B_WE = 1'($urandom);
        A_ADDR = 11'($urandom); B_ADDR = 11'($urandom);
        A_WDATA = 8'($urandom); B_WDATA = 8'($urandom);
      end
      if (i == lat) begin E_ACK = 1'b1; eng_val = rd; end
      tick;
      if (i < e) begin
        checks++;
        if (E_WR !== we || E_RD !== !we || E_ADDR !== ad || A_DONE || B_DONE ||
            E_DATA !== (we ? wd : eng_val)) begin
          failures++;
          $display("FAIL %s hold[%0d]: E_WR=%b E_RD=%b E_ADDR=%h E_DATA=%h DONE=%b%b want %b %b %h %h 00",
                   tag, i, E_WR, E_RD, E_ADDR, E_DATA, A_DONE, B_DONE, we, !we, ad,
                   we ? wd : eng_val);
        end
      end
    end
    if (acked && !we) exp_rdata = rd;
    checks++;
    if (A_DONE !== !g_b || B_DONE !== g_b || ERR !== !acked || RDATA !== exp_rdata ||
        E_WR !== 1'b0 || E_RD !== 1'b0 || BUSY !== 1'b1) begin
      failures++;
      $display("FAIL %s resp: A_DONE=%b B_DONE=%b ERR=%b RDATA=%h E_WR=%b E_RD=%b BUSY=%b want %b %b %b %h 0 0 1",
               tag, A_DONE, B_DONE, ERR, RDATA, E_WR, E_RD, BUSY, !g_b, g_b, !acked, exp_rdata);
    end
    @(negedge CLK);
    E_ACK = 1'b0;
    eng_val = 8'h00;
    tick;
    checks++;
    if (A_DONE || B_DONE || ERR || E_WR || E_RD || BUSY !== 1'b1 || RDATA !== exp_rdata) begin
      failures++;
      $display("FAIL %s gap: DONE=%b%b ERR=%b E_WR=%b E_RD=%b BUSY=%b RDATA=%h want 00 0 0 0 1 %h",
               tag, A_DONE, B_DONE, ERR, E_WR, E_RD, BUSY, RDATA, exp_rdata);
    end
    tick;
    checks++;
    if (A_DONE || B_DONE || E_WR || E_RD || BUSY !== 1'b0) begin
      failures++;
      $display("FAIL %s idle: DONE=%b%b E_WR=%b E_RD=%b BUSY=%b want 00 0 0 0",
               tag, A_DONE, B_DONE, E_WR, E_RD, BUSY);
    end
  endtask

  task automatic test_reset;
    RESET = 1'b0;
    {A_REQ, B_REQ, A_WE, B_WE, E_ACK} = '0;
    A_ADDR = '0; B_ADDR = '0; A_WDATA = '0; B_WDATA = '0;
    eng_val = 8'h00;
    repeat (3) tick;
    checks++;
    if (E_WR || E_RD || E_ADDR !== 11'h0 || A_DONE || B_DONE || ERR || RDATA !== 8'h00 ||
        BUSY || E_DATA !== 8'h00) begin
      failures++;
      $display("FAIL reset: E_WR=%b E_RD=%b E_ADDR=%h DONE=%b%b ERR=%b RDATA=%h BUSY=%b E_DATA=%h want all zero",
               E_WR, E_RD, E_ADDR, A_DONE, B_DONE, ERR, RDATA, BUSY, E_DATA);
    end
    @(negedge CLK);
    RESET = 1'b1;
    last_is_b = 1'b1;
    exp_rdata = 8'h00;
    tick;
    checks++;
    if (BUSY || E_WR || E_RD) begin
      failures++;
      $display("FAIL reset_release: BUSY=%b E_WR=%b E_RD=%b want 0 0 0", BUSY, E_WR, E_RD);
    end
  endtask

  task automatic test_write_a;
    do_txn(1, 0, 1, 0, 11'h123, 11'h000, 8'hA5, 8'h00, 40, 8'h00, 0, "write_a");
  endtask

  task automatic test_read_b;
    do_txn(0, 1, 0, 0, 11'h000, 11'h7FF, 8'h00, 8'h00, 12, 8'h3C, 0, "read_b");
  endtask

  task automatic test_back_to_back;
    apply_reset;
    for (int k = 0; k < 4; k++)
      do_txn(1, 1, 1, 0, 11'h055, 11'h2AA, 8'h11, 8'h22, int'($urandom_range(0, 10)),
             8'($urandom), 1, "b2b");
    @(negedge CLK);
    A_REQ = 1'b0; B_REQ = 1'b0;
  endtask

  task automatic test_timeout;
    do_txn(1, 0, 0, 0, 11'h0AB, 11'h000, 8'h00, 8'h00, 5, 8'h96, 0, "to_prime");
    do_txn(0, 1, 0, 0, 11'h000, 11'h3CD, 8'h00, 8'h00, 1000, 8'hEE, 0, "to_read");
    do_txn(1, 0, 1, 0, 11'h111, 11'h000, 8'h77, 8'h00, 500, 8'h00, 0, "to_write");
    do_txn(0, 1, 0, 0, 11'h000, 11'h222, 8'h00, 8'h00, TO - 1, 8'h4B, 0, "to_coincide");
  endtask

  task automatic test_random;
    bit ra, rb;
    int lat;
    for (int k = 0; k < 24; k++) begin
      ra = 1'($urandom);
      rb = ra ? 1'($urandom) : 1'b1;
      case ($urandom_range(0, 7))
        0:       lat = TO + int'($urandom_range(0, 40));
        1:       lat = TO - 1;
        default: lat = int'($urandom_range(0, 20));
      endcase
      do_txn(ra, rb, 1'($urandom), 1'($urandom), 11'($urandom), 11'($urandom),
             8'($urandom), 8'($urandom), lat, 8'($urandom), 1'($urandom), "random");
    end
    @(negedge CLK);
    A_REQ = 1'b0; B_REQ = 1'b0;
  endtask

  task automatic test_reset_mid;
    apply_reset;
    @(negedge CLK);
    A_REQ = 1'b1; A_WE = 1'b1; A_ADDR = 11'h321; A_WDATA = 8'h5A;
    tick;
    checks++;
    if (E_WR !== 1'b1 || E_DATA !== 8'h5A) begin
      failures++;
      $display("FAIL mid_start: E_WR=%b E_DATA=%h want 1 5a", E_WR, E_DATA);
    end
    @(negedge CLK);
    A_REQ = 1'b0;
    repeat (3) tick;
    #2;
    RESET = 1'b0;
    #1;
    checks++;
    if (E_WR || E_RD || E_DATA !== 8'h00 || BUSY || E_ADDR !== 11'h0 || A_DONE) begin
      failures++;
      $display("FAIL mid_reset_async: E_WR=%b E_RD=%b E_DATA=%h BUSY=%b E_ADDR=%h A_DONE=%b want 0 0 00 0 000 0",
               E_WR, E_RD, E_DATA, BUSY, E_ADDR, A_DONE);
    end
    @(negedge CLK);
    RESET = 1'b1;
    last_is_b = 1'b1;
    exp_rdata = 8'h00;
    for (int k = 0; k < 6; k++) begin
      tick;
      checks++;
      if (A_DONE || B_DONE || BUSY || E_WR || E_RD) begin
        failures++;
        $display("FAIL mid_no_done[%0d]: DONE=%b%b BUSY=%b E_WR=%b E_RD=%b want 00 0 0 0",
                 k, A_DONE, B_DONE, BUSY, E_WR, E_RD);
      end
    end
    @(negedge CLK);
    E_ACK = 1'b1;
    eng_val = 8'hC3;
    for (int k = 0; k < 2; k++) begin
      tick;
      checks++;
      if (A_DONE || B_DONE || ERR || BUSY || E_WR || E_RD || RDATA !== 8'h00) begin
        failures++;
        $display("FAIL idle_ack[%0d]: DONE=%b%b ERR=%b BUSY=%b E_WR=%b E_RD=%b RDATA=%h want 00 0 0 0 0 00",
                 k, A_DONE, B_DONE, ERR, BUSY, E_WR, E_RD, RDATA);
      end
      @(negedge CLK);
      E_ACK = 1'b0;
      eng_val = 8'h00;
    end
    do_txn(1, 1, 0, 1, 11'h00F, 11'h0F0, 8'h00, 8'h99, 3, 8'h81, 0, "post_reset_tie");
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_write_a;
    test_read_b;
    test_back_to_back;
    test_timeout;
    test_random;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/eeprom_arb.md
EEPROM_ARB -- requirements
Module: eeprom_arb

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 16'd20000, meaning max cycles to wait for E_ACK before abort.
REQ-002 SHALL have port CLK  input  1  system clock; all state on rising edge.
REQ-003 SHALL have port RESET  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports A_REQ / B_REQ  input  1  level request from requester A / B.
REQ-005 SHALL have ports A_WE / B_WE  input  1  1 = write, 0 = read.
REQ-006 SHALL have ports A_ADDR / B_ADDR  input  11  EEPROM byte address.
REQ-007 SHALL have ports A_WDATA / B_WDATA  input  8  write data.
REQ-008 SHALL have ports A_DONE / B_DONE  output  1  one-cycle completion pulse to the granted requester.
REQ-009 SHALL have port ERR  output  1  valid with DONE; 1 = timeout abort.
REQ-010 SHALL have port RDATA  output  8  last read byte, valid from the DONE cycle.
REQ-011 SHALL have port BUSY  output  1  high in any state other than IDLE.
REQ-012 SHALL have ports E_WR / E_RD  output  1  write / read command levels to the EEPROM serial engine.
REQ-013 SHALL have port E_ADDR  output  11  address to the engine.
REQ-014 SHALL have port E_DATA  inout  8  engine parallel data bus.
REQ-015 SHALL have port E_ACK  input  1  one-cycle end-of-operation pulse from the engine.

Function
REQ-016 SHALL implement states IDLE, WAIT_ACK, RESP, GAP, one-hot.
REQ-017 IDLE: if A_REQ or B_REQ is high, SHALL select a port, latch its WE/ADDR/WDATA, and enter WAIT_ACK; E_WR or E_RD SHALL be high in the first cycle after REQ is sampled.
REQ-018 Arbitration: with a single request, that port is granted; with both, the port not granted last is granted; last_grant SHALL reset to B, so A wins the first tie.
REQ-019 WAIT_ACK: SHALL hold E_WR (write) or E_RD (read) high, hold E_ADDR at the latched value, drive E_DATA with latched WDATA for writes, and increment the 16-bit timeout counter each cycle.
REQ-020 E_DATA SHALL be high-impedance in all cases except a write in WAIT_ACK.
REQ-021 On E_ACK=1 in WAIT_ACK: SHALL drop E_WR/E_RD next cycle, capture E_DATA into RDATA if the operation is a read, clear the counter, and enter RESP.
REQ-022 If the counter reaches TIMEOUT_CYC-1 with no E_ACK: SHALL drop E_WR/E_RD, leave RDATA unchanged, set the ERR flag, and enter RESP; if E_ACK and timeout coincide, E_ACK wins with ERR=0.
REQ-023 RESP: SHALL pulse the granted port's DONE for exactly one cycle with ERR valid, then enter GAP.
REQ-024 GAP: SHALL hold E_WR=E_RD=0 for one cycle so the engine returns to idle, then enter IDLE.
REQ-025 Request and input changes after latching SHALL be ignored until IDLE; a REQ still high in IDLE after GAP SHALL start a new transaction.
REQ-026 E_ACK outside WAIT_ACK SHALL be ignored.
REQ-027 E_WR and E_RD SHALL never be high together.

Reset
REQ-028 RESET low SHALL immediately force: state IDLE, E_WR=E_RD=0, E_ADDR=0, E_DATA=Z, DONE=0, ERR=0, RDATA=8'h00, BUSY=0, counter=0, last_grant=B.
REQ-029 Reset during WAIT_ACK SHALL abort with no DONE pulse; the engine is not reset by this block.

Structure
REQ-030 Package eeprom_arb_pkg SHALL hold the state encodings, the TIMEOUT_CYC default, and the port ID constants A=0 and B=1.
REQ-031 A sub-module rr_arb2 (2-way round-robin grant with last_grant register) SHALL be instantiated; all other logic stays in eeprom_arb.

Verification
REQ-032 A write: A_REQ=1, A_WE=1, A_ADDR=11'h123, A_WDATA=8'hA5, E_ACK after 40 cycles -> E_WR high from cycle+1, E_ADDR=123, E_DATA=A5 until E_ACK, A_DONE one cycle, ERR=0.
REQ-033 B read: B_ADDR=11'h7FF, engine drives E_DATA=8'h3C with E_ACK -> RDATA=3C at B_DONE; E_DATA=Z throughout from this block.
REQ-034 Both REQ high continuously after reset -> grants A,B,A,B, each separated by a RESP+GAP with E_WR/E_RD low.
REQ-035 TIMEOUT_CYC=100, no E_ACK -> E_RD drops after 100 WAIT_ACK cycles, DONE with ERR=1, RDATA unchanged.
REQ-036 RESET low mid-WAIT_ACK -> E_WR=0 and E_DATA=Z without waiting for a clock edge, no DONE; E_ACK pulse in IDLE -> no output change.
